// File: rtl/label_encoder.sv
// One-hot switch bank to 4-bit gesture class encoder: sync, debounce, one code per press
// over valid/ready, multi-hot flagged on code_err. Define LABEL_ENCODER_DEBOUNCE_EN to enable debounce.
module label_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_in,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [3:0] code_out,
    output logic       code_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, REPORT, WAIT_REL} state_t;

    state_t     state;
    logic [7:0] sync1, sync2, stable_q;
    logic       one_hot, multi;
    logic [2:0] enc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

`ifdef LABEL_ENCODER_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;

    // cnt saturates at CNT_MAX, so a held pattern keeps reloading the same stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            cnt      <= '0;
            stable_q <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
            stable_q <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = &{1'b0, DEBOUNCE_CYCLES[0], CNT_W[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stable_q <= '0;
        else        stable_q <= sync2;
    end
`endif

    // bit7 maps to class 0, bit0..bit6 to classes 1..7
    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 7; i++)
            if (stable_q[i]) enc = 3'(i + 1);
    end

    assign one_hot = (stable_q != 8'h00) && ((stable_q & (stable_q - 8'h01)) == 8'h00);
    assign multi   = (stable_q != 8'h00) && !one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code_valid <= 1'b0;
            code_out   <= 4'd0;
            code_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            code_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state      <= REPORT;
                        code_valid <= 1'b1;
                        code_out   <= {1'b0, enc};
                        busy       <= 1'b1;
                    end else if (multi) begin
                        state    <= WAIT_REL;
                        code_err <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                REPORT: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        if (stable_q != 8'h00) begin
                            state <= WAIT_REL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                WAIT_REL: begin
                    // a held button must be fully released before another code is issued
                    if (stable_q == 8'h00) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    code_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_label_encoder.sv
// Randomized + directed bench for label_encoder against a press-level reference model.
module tb_label_encoder;

    localparam int D = 4;
`ifdef LABEL_ENCODER_DEBOUNCE_EN
    localparam int WIN     = D + 1;
    localparam int LAT     = D + 4;
    localparam int GLIT_N  = 1;
    localparam int PULSE_N = 0;
`else
    localparam int WIN     = 1;
    localparam int LAT     = 4;
    localparam int GLIT_N  = 2;
    localparam int PULSE_N = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       code_ready = 1'b0;
    logic       code_valid, code_err, busy;
    logic [3:0] code_out;

    label_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .code_ready(code_ready),
        .code_valid(code_valid), .code_out(code_out), .code_err(code_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cls(input logic [7:0] v);
        for (int i = 0; i < 7; i++)
            if (v[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    // Reference: an input pattern becomes stable once WIN consecutive synchronized
    // samples agree; a press yields one code, then a full release is required.
    logic [7:0] hist[$];
    logic [7:0] win[$];
    logic [7:0] m_stable;
    bit         m_pend, m_hold, m_err;
    logic [3:0] m_code;
    int         m_xfer = 0, m_errs = 0;

    always @(posedge clk or negedge rst_n) begin : mdl
        logic [7:0] s2;
        bit same;
        if (!rst_n) begin
            hist.delete();
            win.delete();
            for (int i = 0; i < WIN; i++) win.push_back(8'h00);
            m_stable = 8'h00;
            m_pend = 0; m_hold = 0; m_err = 0; m_code = 4'd0;
        end else begin
            m_err = 0;
            if (m_pend) begin
                if (code_ready) begin
                    m_pend = 0;
                    m_xfer++;
                    m_hold = (m_stable != 8'h00);
                end
            end else if (m_hold) begin
                if (m_stable == 8'h00) m_hold = 0;
            end else if ($countones(m_stable) == 1) begin
                m_pend = 1;
                m_code = cls(m_stable);
            end else if (m_stable != 8'h00) begin
                m_err = 1;
                m_errs++;
                m_hold = 1;
            end
            s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 8'h00;
            hist.push_back(sw_in);
            if (hist.size() > 2) void'(hist.pop_front());
            win.push_back(s2);
            void'(win.pop_front());
            same = 1;
            foreach (win[i]) if (win[i] != s2) same = 0;
            if (same) m_stable = s2;
        end
    end

    int         xfer_cnt = 0, err_cnt = 0;
    logic [3:0] last_code = 4'd0;

    always @(posedge clk) begin
        if (rst_n && code_valid && code_ready) begin
            xfer_cnt++;
            last_code = code_out;
        end
        if (rst_n && code_err) err_cnt++;
        #1;
        chk("valid", code_valid, m_pend);
        chk("err", code_err, m_err);
        chk("busy", busy, m_pend || m_hold);
        if (m_pend) chk("code", code_out, m_code);
    end

    task automatic drive(input logic [7:0] p, input logic r, input int n);
        @(negedge clk);
        sw_in = p;
        code_ready = r;
        repeat (n) @(posedge clk);
    endtask

    logic [7:0] pats [8] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    initial begin
        int lat, b, be;
        logic [7:0] p;
        rst_n = 1'b0; sw_in = 8'h80; code_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", code_valid, 0);
        chk("rst_code", code_out, 0);
        chk("rst_err", code_err, 0);
        chk("rst_busy", busy, 0);

        @(negedge clk); rst_n = 1'b1; lat = 0;
        for (int e = 1; e <= LAT + 6; e++) begin
            @(posedge clk); #1;
            if (code_valid && lat == 0) lat = e;
        end
        chk("latency", lat, LAT);
        drive(8'h00, 1'b1, LAT + 4);

        for (int i = 0; i < 8; i++) begin
            b = xfer_cnt;
            drive(pats[i], 1'b1, LAT + 4);
            drive(8'h00, 1'b1, LAT + 4);
            chk("map_n", xfer_cnt - b, 1);
            chk("map_code", last_code, i);
        end

        b = xfer_cnt;
        drive(8'h04, 1'b0, 10);
        drive(8'h00, 1'b0, 10);
        chk("bp_valid", code_valid, 1);
        chk("bp_code", code_out, 3);
        drive(8'h00, 1'b1, 3);
        chk("bp_n", xfer_cnt - b, 1);
        chk("bp_busy", busy, 0);

        b = xfer_cnt;
        drive(8'h10, 1'b1, 3);
        drive(8'h00, 1'b1, 1);
        drive(8'h10, 1'b1, LAT + 4);
        drive(8'h00, 1'b1, LAT + 4);
        chk("glitch_n", xfer_cnt - b, GLIT_N);
        chk("glitch_code", last_code, 5);

        b = xfer_cnt; be = err_cnt;
        drive(8'h03, 1'b1, LAT + 4);
        drive(8'h00, 1'b1, LAT + 4);
        chk("multi_err", err_cnt - be, 1);
        chk("multi_n", xfer_cnt - b, 0);
        drive(8'h01, 1'b1, LAT + 4);
        drive(8'h00, 1'b1, LAT + 4);
        chk("after_multi_n", xfer_cnt - b, 1);
        chk("after_multi_code", last_code, 1);

        b = xfer_cnt;
        drive(8'h01, 1'b1, 1);
        drive(8'h00, 1'b1, LAT + 6);
        chk("pulse_n", xfer_cnt - b, PULSE_N);

        drive(8'h02, 1'b0, LAT + 2);
        chk("pre_rst_valid", code_valid, 1);
        @(negedge clk); rst_n = 1'b0; sw_in = 8'h00;
        #1;
        chk("mid_rst_valid", code_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        b = xfer_cnt;
        drive(8'h00, 1'b1, LAT + 4);
        chk("rst_drop", xfer_cnt - b, 0);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: p = 8'h00;
                1: p = 8'(1 << $urandom_range(0, 7));
                2: p = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
                default: p = 8'($urandom);
            endcase
            drive(p, $urandom_range(0, 3) != 0, $urandom_range(1, LAT + 6));
        end

        drive(8'h00, 1'b1, LAT + 20);
        chk("xfer_total", xfer_cnt, m_xfer);
        chk("err_total", err_cnt, m_errs);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/label_encoder.md
Name: label_encoder

Overview:
- Reverse direction of the gesture-class LED decoder: reads an 8-bit one-hot switch/button bank and encodes the pressed position into a 4-bit gesture class code.
- Used for operator labelling of captured samples and for injecting test classes.
- Output uses the same position-to-class map as the LED decoder: bit7 -> class 0, bit0..bit6 -> class 1..7.
- Synchronizes and debounces inputs, reports one code per press over a valid/ready handshake, and flags multi-hot presses.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must hold steady before it is accepted (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, width of the debounce counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_in  input  8  raw, asynchronous switch/button levels; active high.
- code_ready  input  1  consumer accepts code_out when high together with code_valid.
- code_valid  output  1  code_out holds an unaccepted class code.
- code_out  output  4  encoded class, 0..7.
- code_err  output  1  one-cycle pulse on an accepted multi-hot pattern.
- busy  output  1  high in every FSM state other than IDLE.

Behaviour:
- Reset values (asynchronous reset, all registers):
  - sync1, sync2, cand, stable_q and cnt clear to 0.
  - code_valid=0, code_out=4'd0, code_err=0, busy=0.
  - FSM goes to IDLE.
  - Reset asserted mid-handshake drops the pending code with no further output.
- Synchronizer: 2-flop chain sw_in -> sync1 -> sync2.
- Debounce:
  - If sync2 != cand: load cand with sync2 and clear cnt to 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: load stable_q with cand; cnt holds.
  - Otherwise: cnt increments.
  - A single-cycle glitch restarts the count.
- Encode, combinational from stable_q:
  - Exactly one bit set: class per the map; bit7=0, bit0=1, bit1=2 ... bit6=7.
  - Zero bits set: none.
  - Two or more bits set: multi.
- FSM states and transitions:
  - IDLE: stable_q one-hot -> REPORT; code_out loaded, code_valid=1 on the same edge. Stable_q multi -> WAIT_REL; code_err=1 for that cycle. Stable_q zero -> stay in IDLE.
  - REPORT: code_valid and code_out held constant until an edge where code_valid&&code_ready. On that edge: code_valid=0; next state WAIT_REL if stable_q != 0, else IDLE. Inputs released or changed during REPORT do not alter code_out.
  - WAIT_REL: stay until stable_q == 0, then IDLE. No new code without a full release, so holding a button yields exactly one code.
- Latency: with sw_in held constant from edge 1 (first sampling edge), stable_q updates at edge DEBOUNCE_CYCLES+3 and code_valid rises at edge DEBOUNCE_CYCLES+4.
- code_ready high while in IDLE is ignored.
- code_valid never deasserts without a transfer, except on reset.
- code_err and code_valid are never high in the same cycle.
- Simultaneous events: a stable_q change on the transfer edge is evaluated by the next state on the following cycle.

Optional Feature:
- Macro: LABEL_ENCODER_DEBOUNCE_EN.
- Defined: debounce as above; cnt and cand present.
- Undefined:
  - cnt and cand are removed; stable_q loads sync2 every cycle.
  - Latency from edge 1 to code_valid is 4 edges.
  - DEBOUNCE_CYCLES and CNT_W are unused.
  - FSM, encoding and handshake are unchanged.

Test Plan (DEBOUNCE_CYCLES=4, macro defined unless stated):
- Reset: hold rst_n=0 with sw_in=8'h80 -> code_valid=0, code_out=0, code_err=0, busy=0. Release reset with 8'h80 held -> code_valid rises on edge 8 after the first sampling edge.
- Full map: each one-hot pattern, code_ready=1, with a release between presses -> 8'h80->0, 8'h01->1, 8'h02->2, 8'h04->3, 8'h08->4, 8'h10->5, 8'h20->6, 8'h40->7; exactly one code_valid cycle per press.
- Backpressure: press 8'h04 with code_ready=0 for 20 cycles, release the button at cycle 10, then set code_ready=1 -> code_valid=1 and code_out=3 throughout; one transfer; then IDLE.
- Glitch: 8'h10 for 3 cycles, then 0, then 8'h10 held -> no output from the first pulse; a single code 5 follows the held press at full latency.
- Multi-hot: 8'h03 held -> one code_err pulse, no code_valid. Release, then 8'h01 -> code 1.
- Macro undefined: 8'h20 -> code_valid at edge 4 with code_out=6. A 1-cycle glitch 8'h01 -> code 1 is emitted, because no debounce is applied.
